vec_normalize: RTL and testbench
================================

# vec_normalize

Downstream companion of the inverse-square-root pipeline. It takes the same x/y/z vector that feeds the inverse-square-root stage, delays it to line up with that stage's 1Q24 result, and multiplies each component by the result. The output is a unit-length vector in signed 1Q14, consumed by the lighting and shading stages. It is a fully pipelined design with one vector per cycle, no stall, and a valid bit carried alongside the data.

## Interface
- INV_LAT, 12, cycles from x/y/z presented to the inverse-square-root stage until its `out` is valid
- OUT_W, 16, output component width (signed 1Q14)
- clk  in  1  clock; all flops rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  vector on x/y/z is valid this cycle; the same x/y/z drive the inverse-square-root stage in the same cycle
- x, y, z  in  24 each  signed two's complement, 12 fractional bits
- inv_len  in  25  inverse-square-root result, 1Q24, non-negative; valid exactly INV_LAT cycles after the matching x/y/z
- out_valid  out  1  nx/ny/nz valid
- nx, ny, nz  out  OUT_W each  signed 1Q14 normalized components
- out_zero  out  1  the input vector was (0,0,0); meaningful when out_valid=1
- sat_cnt  out  16  saturating count of output vectors with at least one clamped component

## Operation
- Delay line: {in_valid, x, y, z, zero} is shifted by INV_LAT stages, where zero = (x==0 && y==0 && z==0). Only the valid bit is reset; data bits are not.
- Stage M (registered): p_c = $signed(c_d) * $signed({1'b0, inv_len}). Each product is 50-bit signed with Q36 scaling.
- Stage R (registered):
  - r_c = (p_c + 2^21) >>> 22. This is round-half-up, so −0.5 LSB rounds to 0.
  - Clamp to [−32768, 32767].
  - sat_hit is the OR of the three per-component clamp flags.
- sat_cnt increments by 1 on each out_valid cycle with sat_hit=1. It holds at 0xFFFF.
- No handshake backpressure. Every accepted in_valid yields exactly one out_valid, in input order.

## Timing
- Latency: out_valid rises INV_LAT+2 cycles after the in_valid cycle. Throughput is 1 vector per cycle.
- Back-to-back and gapped inputs keep their spacing exactly at the output.
- Reset values: out_valid=0, nx=ny=nz=0, out_zero=0, sat_cnt=0. All take effect on the first clk edge with rst=1.
- Reset mid-operation: all in-flight valid bits are cleared. No vector sampled before or during rst ever produces out_valid.
  - in_valid sampled while rst=1 is ignored.
  - The first vector accepted is the one with in_valid=1 on the first cycle with rst=0.
- rst takes priority over a simultaneous sat_cnt increment.
- nx/ny/nz/out_zero are registered every cycle. Their values are don't-care when out_valid=0, except after reset, when they are 0.

## Configuration
- VEC_NORMALIZE_ZERO_GUARD_EN defined:
  - When out_zero=1, nx=ny=nz=0 regardless of inv_len.
  - sat_cnt does not count that vector.
- Undefined:
  - The zero flag and its delay-line bit are removed, and out_zero is tied to 0.
  - Zero vectors pass through the raw multiply. This gives 0 anyway, since the components are 0; only the flag is lost.

## Structure
- Package vec_norm_pkg holds:
  - INV_LAT default, IN_W=24, INV_W=25, OUT_W=16
  - RND_SHIFT=22, RND_BIAS=2^21
  - OUT_MAX=32767, OUT_MIN=−32768
- Sub-module vec_delay_line: a parameterized-depth shift register holding a resettable valid bit and a non-reset payload. It is instantiated once with payload {zero, x, y, z}.
- Multiply, round and clamp stay in vec_normalize.

## Test plan
- Basic: x=12288 (3.0), y=16384 (4.0), z=0, inv_len=3355443 (0.2) → after 14 cycles: nx=9830, ny=13107, nz=0, out_zero=0, sat_cnt=0.
- Saturation: x=−32768 (−8.0), y=z=0, inv_len=8388608 (0.5) → nx=−32768 (clamped), sat_cnt=1. Repeat 70000 vectors → sat_cnt holds at 65535.
- Rounding: x=1, inv_len=2^21 → nx=1. x=−1, inv_len=2^21 → nx=0.
- Zero guard (macro defined): x=y=z=0, inv_len=0x1FFFFFF → nx=ny=nz=0, out_zero=1, sat_cnt unchanged.
- Streaming: 20 consecutive in_valid vectors, then a gap of 3, then 5 more → 20 consecutive out_valid, a gap of 3, then 5, each matching a reference model in order.
- Reset mid-flight: in_valid at cycle 0, rst=1 at cycle 5 for one cycle → no out_valid at cycle 14. Outputs are 0 from cycle 6; a new vector at cycle 7 emerges at cycle 21.

Source files
------------

// File: rtl/vec_norm_pkg.sv
// vec_norm_pkg: shared widths, rounding constants, payload type and
// the round/clamp helper for the vec_normalize pipeline.
package vec_norm_pkg;

    localparam int INV_LAT_DEF = 12;
    localparam int IN_W        = 24;
    localparam int INV_W       = 25;
    localparam int OUT_W       = 16;
    localparam int PROD_W      = IN_W + INV_W + 1;

    localparam int RND_SHIFT = 22;
    localparam logic signed [PROD_W-1:0] RND_BIAS = PROD_W'(2097152);

    localparam int OUT_MAX = 32767;
    localparam int OUT_MIN = -32768;

`ifdef VEC_NORMALIZE_ZERO_GUARD_EN
    typedef struct packed {
        logic                   zero;
        logic signed [IN_W-1:0] x;
        logic signed [IN_W-1:0] y;
        logic signed [IN_W-1:0] z;
    } vec_pl_t;
`else
    typedef struct packed {
        logic signed [IN_W-1:0] x;
        logic signed [IN_W-1:0] y;
        logic signed [IN_W-1:0] z;
    } vec_pl_t;
`endif

    // Q36 product -> Q14, round half up, clamp. MSB of result = clamped.
    function automatic logic [OUT_W:0] rnd_clamp(
        input logic signed [PROD_W-1:0] p
    );
        logic signed [PROD_W-1:0] s;
        logic signed [PROD_W-1:0] q;
        s = p + RND_BIAS;
        q = s >>> RND_SHIFT;
        if (q > OUT_MAX)
            return {1'b1, OUT_W'(OUT_MAX)};
        else if (q < OUT_MIN)
            return {1'b1, OUT_W'(OUT_MIN)};
        else
            return {1'b0, q[OUT_W-1:0]};
    endfunction

endpackage

// File: rtl/vec_delay_line.sv
// vec_delay_line: DEPTH-stage shift register, resettable valid bit
// plus non-reset payload. Ports: clk, rst, in_valid/in_data, out_valid/out_data.
module vec_delay_line #(
    parameter int DEPTH = 12,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0] vld;
    logic [W-1:0]     dat [DEPTH];

    always_ff @(posedge clk) begin
        if (rst)
            vld <= '0;
        else
            vld <= {vld[DEPTH-2:0], in_valid};
    end

    always_ff @(posedge clk) begin
        dat[0] <= in_data;
        for (int i = 1; i < DEPTH; i++)
            dat[i] <= dat[i-1];
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/vec_normalize.sv
// vec_normalize: scales x/y/z (Q12) by the delayed 1Q24 inverse length
// to a 1Q14 unit vector. Optional macro: VEC_NORMALIZE_ZERO_GUARD_EN.
// Ports: clk, rst, in_valid, x, y, z, inv_len -> out_valid, nx, ny, nz,
// out_zero, sat_cnt (saturating count of clamped output vectors).
module vec_normalize
    import vec_norm_pkg::*;
#(
    parameter int INV_LAT = INV_LAT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  x,
    input  logic signed [IN_W-1:0]  y,
    input  logic signed [IN_W-1:0]  z,
    input  logic        [INV_W-1:0] inv_len,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] nx,
    output logic signed [OUT_W-1:0] ny,
    output logic signed [OUT_W-1:0] nz,
    output logic                    out_zero,
    output logic        [15:0]      sat_cnt
);

    vec_pl_t pl_in;
    vec_pl_t d;
    logic    d_valid;

    always_comb begin
        pl_in   = '0;
        pl_in.x = x;
        pl_in.y = y;
        pl_in.z = z;
`ifdef VEC_NORMALIZE_ZERO_GUARD_EN
        pl_in.zero = (x == '0) && (y == '0) && (z == '0);
`endif
    end

    vec_delay_line #(
        .DEPTH (INV_LAT),
        .W     ($bits(vec_pl_t))
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (pl_in),
        .out_valid (d_valid),
        .out_data  (d)
    );

    logic                     v_m;
    logic signed [PROD_W-1:0] px, py, pz;
    logic signed [PROD_W-1:0] inv_s;

    assign inv_s = PROD_W'($signed({1'b0, inv_len}));

    always_ff @(posedge clk) begin
        if (rst)
            v_m <= 1'b0;
        else
            v_m <= d_valid;
    end

    always_ff @(posedge clk) begin
        px <= PROD_W'(d.x) * inv_s;
        py <= PROD_W'(d.y) * inv_s;
        pz <= PROD_W'(d.z) * inv_s;
    end

    logic [OUT_W:0] cx, cy, cz;
    logic           keep;
    logic           sat_hit;

    assign cx = rnd_clamp(px);
    assign cy = rnd_clamp(py);
    assign cz = rnd_clamp(pz);

`ifdef VEC_NORMALIZE_ZERO_GUARD_EN
    logic zero_m;

    always_ff @(posedge clk) begin
        zero_m <= d.zero;
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_zero <= 1'b0;
        else
            out_zero <= v_m & zero_m;
    end

    assign keep = v_m & ~zero_m;
`else
    assign out_zero = 1'b0;
    assign keep     = v_m;
`endif

    assign sat_hit = keep & (cx[OUT_W] | cy[OUT_W] | cz[OUT_W]);

    // Data is forced to 0 on idle cycles so post-reset outputs stay 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            nx        <= '0;
            ny        <= '0;
            nz        <= '0;
            sat_cnt   <= '0;
        end else begin
            out_valid <= v_m;
            nx        <= keep ? cx[OUT_W-1:0] : '0;
            ny        <= keep ? cy[OUT_W-1:0] : '0;
            nz        <= keep ? cz[OUT_W-1:0] : '0;
            if (sat_hit && sat_cnt != 16'hFFFF)
                sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_vec_normalize.sv
// tb_vec_normalize: directed vectors, real-arithmetic reference model
// and a per-cycle compare process with literal pins.
module tb_vec_normalize;

    localparam int LAT = 12;
    localparam int N   = 70260;

`ifdef VEC_NORMALIZE_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [23:0] x, y, z;
    logic        [24:0] inv_len;
    logic               out_valid;
    logic signed [15:0] nx, ny, nz;
    logic               out_zero;
    logic        [15:0] sat_cnt;

    int checks = 0;
    int errors = 0;

    bit s_rst[];
    bit s_vld[];
    bit e_vld[];
    int s_x[];
    int s_y[];
    int s_z[];
    int s_inv[];

    always #5 clk = ~clk;

    vec_normalize #(.INV_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .z         (z),
        .inv_len   (inv_len),
        .out_valid (out_valid),
        .nx        (nx),
        .ny        (ny),
        .nz        (nz),
        .out_zero  (out_zero),
        .sat_cnt   (sat_cnt)
    );

    task automatic chk(input string nm, input int t,
                       input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d",
                     nm, t, act, exp);
        end
    endtask

    task automatic add_vec(input int t, input int vx, input int vy,
                           input int vz, input int vinv);
        s_vld[t]       = 1'b1;
        s_x[t]         = vx;
        s_y[t]         = vy;
        s_z[t]         = vz;
        s_inv[t + LAT] = vinv;
    endtask

    // c * inv / 2^22, rounded half up, clamped to 16-bit signed.
    function automatic int model(input int c, input int inv,
                                 output bit hit);
        real    v;
        longint r;
        v   = real'(c) * real'(inv) / 4194304.0;
        r   = longint'($floor(v + 0.5));
        hit = 1'b0;
        if (r > 32767) begin
            r   = 32767;
            hit = 1'b1;
        end else if (r < -32768) begin
            r   = -32768;
            hit = 1'b1;
        end
        return int'(r);
    endfunction

    initial begin
        bit ok;
        s_rst = new[N];
        s_vld = new[N];
        e_vld = new[N];
        s_x   = new[N];
        s_y   = new[N];
        s_z   = new[N];
        s_inv = new[N];

        s_rst[0] = 1'b1;
        s_rst[1] = 1'b1;
        s_rst[2] = 1'b1;

        add_vec(3, 12288, 16384, 0, 3355443);
        add_vec(4, -32768, 0, 0, 8388608);
        add_vec(5, 1, 0, 0, 2097152);
        add_vec(6, -1, 0, 0, 2097152);
        add_vec(7, 0, 0, 0, 33554431);
        add_vec(8, 30000, 0, 0, 33554431);

        for (int i = 0; i < 25; i++) begin
            int t;
            t = (i < 20) ? 20 + i : 23 + i;
            add_vec(t, ((i * 331771) % 8000000) - 4000000,
                    ((i * 52711) % 600000) - 300000,
                    4000 - i * 1777,
                    1 + (i * 1234567) % 33554432);
        end

        add_vec(100, 40960, -4096, 8192, 4194304);
        add_vec(105, 4096, 4096, 4096, 4194304);
        s_rst[105] = 1'b1;
        add_vec(107, -20480, 12288, 4096, 1000000);

        for (int i = 0; i < 70000; i++)
            add_vec(200 + i, -32768, 0, 0, 8388608);

        for (int s = 0; s + LAT + 2 < N; s++) begin
            if (s_vld[s]) begin
                ok = 1'b1;
                for (int k = s; k < s + LAT + 2; k++)
                    if (s_rst[k]) ok = 1'b0;
                e_vld[s + LAT + 2] = ok;
            end
        end

        for (int t = 0; t < N; t++) begin
            rst      = s_rst[t];
            in_valid = s_vld[t];
            x        = 24'(s_x[t]);
            y        = 24'(s_y[t]);
            z        = 24'(s_z[t]);
            inv_len  = 25'(s_inv[t]);
            @(posedge clk);
            #1;
        end
    end

    initial begin
        int cnt;
        bit post_rst;
        int s;
        int ex, ey, ez;
        bit hx, hy, hz;
        bit zv;
        cnt      = 0;
        post_rst = 1'b0;
        for (int t = 1; t < N; t++) begin
            @(negedge clk);
            if (s_rst[t-1]) begin
                cnt      = 0;
                post_rst = 1'b1;
            end
            chk("out_valid", t, out_valid, e_vld[t]);
            if (e_vld[t]) begin
                s  = t - LAT - 2;
                ex = model(s_x[s], s_inv[s + LAT], hx);
                ey = model(s_y[s], s_inv[s + LAT], hy);
                ez = model(s_z[s], s_inv[s + LAT], hz);
                zv = (s_x[s] == 0) && (s_y[s] == 0) && (s_z[s] == 0);
                if (GUARD && zv) begin
                    ex = 0; ey = 0; ez = 0;
                    hx = 0; hy = 0; hz = 0;
                end
                chk("nx", t, nx, ex);
                chk("ny", t, ny, ey);
                chk("nz", t, nz, ez);
                chk("out_zero", t, out_zero, GUARD && zv);
                if ((hx || hy || hz) && cnt < 65535) cnt++;
                post_rst = 1'b0;
            end else if (post_rst) begin
                chk("rst_nx", t, nx, 0);
                chk("rst_ny", t, ny, 0);
                chk("rst_nz", t, nz, 0);
                chk("rst_out_zero", t, out_zero, 0);
            end
            chk("sat_cnt", t, sat_cnt, cnt);

            case (t)
                17: begin
                    chk("lit_basic_nx", t, nx, 9830);
                    chk("lit_basic_ny", t, ny, 13107);
                    chk("lit_basic_nz", t, nz, 0);
                    chk("lit_basic_sat", t, sat_cnt, 0);
                end
                18: begin
                    chk("lit_sat_nx", t, nx, -32768);
                    chk("lit_sat_cnt", t, sat_cnt, 1);
                end
                19: chk("lit_rnd_pos", t, nx, 1);
                20: chk("lit_rnd_neg", t, nx, 0);
                21: begin
                    chk("lit_zero_flag", t, out_zero, GUARD);
                    chk("lit_zero_nx", t, nx, 0);
                    chk("lit_zero_sat", t, sat_cnt, 1);
                end
                22: chk("lit_pos_clamp", t, nx, 32767);
                114: chk("lit_rst_drop", t, out_valid, 0);
                121: chk("lit_rst_new", t, out_valid, 1);
                default: ;
            endcase
        end
        chk("lit_sat_hold", N, sat_cnt, 65535);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
